// File: rtl/vedic_cascaded_multiplier.sv
// Sequential WIDTHxWIDTH -> 2*WIDTH unsigned multiplier built on one shared HALFxHALF
// Urdhva-Tiryagbhyam core. Define VEDIC_MUL_ADDEND_EN to add the addend port (product = A*B + addend).
`timescale 1ns/1ps

module vedic_urdhva_core #(
  parameter int HALF = 16
) (
  input  logic [HALF-1:0]   a,
  input  logic [HALF-1:0]   b,
  output logic [2*HALF-1:0] p
);

  logic [31:0] col;

  // Column k collects every crosswise bit product a[i]*b[j] with i+j == k; the carry rolls into k+1.
  always_comb begin
    p   = '0;
    col = '0;
    for (int k = 0; k < 2*HALF-1; k++) begin
      for (int i = 0; i < HALF; i++) begin
        for (int j = 0; j < HALF; j++) begin
          if (i + j == k) col = col + 32'(a[i] & b[j]);
        end
      end
      p[k] = col[0];
      col  = col >> 1;
    end
    p[2*HALF-1] = col[0];
  end

endmodule

module vedic_cascaded_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
`ifdef VEDIC_MUL_ADDEND_EN
  input  logic [WIDTH-1:0]   addend,
`endif
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int HALF = WIDTH / 2;
  localparam int PW   = 2 * WIDTH;

  typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [PW-1:0]     acc_q, product_q;
  logic              busy_q, done_q;
  logic [HALF-1:0]   core_a, core_b;
  logic [WIDTH-1:0]  core_p;
  logic [PW-1:0]     pp_base, pp_shifted, acc_sum, acc_init;

`ifdef VEDIC_MUL_ADDEND_EN
  assign acc_init = {{WIDTH{1'b0}}, addend};
`else
  assign acc_init = '0;
`endif

  vedic_urdhva_core #(.HALF(HALF)) u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  // Next state and selection of the operand halves fed to the shared core.
  always_comb begin
    state_d = state_q;
    core_a  = a_q[HALF-1:0];
    core_b  = b_q[HALF-1:0];
    case (state_q)
      IDLE: if (start) state_d = PP0;
      PP0:  state_d = PP1;
      PP1: begin
        state_d = PP2;
        core_a  = a_q[WIDTH-1:HALF];
      end
      PP2: begin
        state_d = PP3;
        core_b  = b_q[WIDTH-1:HALF];
      end
      PP3: begin
        state_d = DONE;
        core_a  = a_q[WIDTH-1:HALF];
        core_b  = b_q[WIDTH-1:HALF];
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pp_base = {{WIDTH{1'b0}}, core_p};

  always_comb begin
    case (state_q)
      PP1, PP2: pp_shifted = pp_base << HALF;
      PP3:      pp_shifted = pp_base << WIDTH;
      default:  pp_shifted = pp_base;
    endcase
  end

  assign acc_sum = acc_q + pp_shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == PP3);
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= multiplicand;
            b_q   <= multiplier;
            acc_q <= acc_init;
          end
        end
        PP0, PP1, PP2: acc_q     <= acc_sum;
        PP3:           product_q <= acc_sum;
        default: ;
      endcase
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_vedic_cascaded_multiplier.sv
// Bench for vedic_cascaded_multiplier: fixed vector table, randomized operands against an
// arithmetic model, and hand sequences for start-while-busy, held start and mid-operation reset.
`timescale 1ns/1ps

module tb_vedic_cascaded_multiplier;

`ifdef VEDIC_MUL_ADDEND_EN
  localparam bit ADD_EN = 1'b1;
`else
  localparam bit ADD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] multiplicand, multiplier, addend;
  logic [63:0] product;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ad;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  vedic_cascaded_multiplier #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
`ifdef VEDIC_MUL_ADDEND_EN
    .addend       (addend),
`endif
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] ad);
    logic [63:0] r;
    r = 64'(a) * 64'(b);
    if (ADD_EN) r = r + 64'(ad);
    return r;
  endfunction

  // One full operation: checks result, done timing, single done pulse and busy duration.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ad,
                       input logic [63:0] exp, input string tag);
    int done_at, done_cnt, busy_cnt;
    logic [63:0] got;
    done_at = -1; done_cnt = 0; busy_cnt = 0; got = '0;
    @(negedge clk);
    multiplicand = a; multiplier = b; addend = ad; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          got = product;
        end
      end
      @(posedge clk); #1;
    end
    chk({tag, ".product"}, got, exp);
    chk({tag, ".done_edge"}, 64'(done_at), 64'd4);
    chk({tag, ".done_count"}, 64'(done_cnt), 64'd1);
    chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd5);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt, first, second;
    logic [63:0] snap;
    logic [31:0] ra, rb, rad;

    vecs.push_back('{32'h0001_0000, 32'h0001_0000, 32'h0, 64'h0000_0001_0000_0000});
    vecs.push_back('{32'h0000_FFFF, 32'h0001_0001, 32'h0, 64'h0000_0000_FFFF_FFFF});
    vecs.push_back('{32'h0000_0002, 32'h8000_0000, 32'h0, 64'h0000_0001_0000_0000});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 64'hFFFF_FFFE_0000_0001});
    vecs.push_back('{32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 64'h0});
    vecs.push_back('{32'h0000_0003, 32'h0000_0005, 32'h0, 64'd15});
`ifdef VEDIC_MUL_ADDEND_EN
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000});
    vecs.push_back('{32'h0000_1234, 32'h0000_0007, 32'h0000_0003, 64'h0000_0000_0000_7F6F});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF});
`endif

    rst_n = 1'b0; start = 1'b0;
    multiplicand = '0; multiplier = '0; addend = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.product", product, 64'h0);
    chk("reset.busy", 64'(busy), 64'h0);
    chk("reset.done", 64'(done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].ad, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom; rad = $urandom;
      if (i == 0) ra = 32'hFFFF_0000;
      if (i == 1) rb = 32'h0000_FFFF;
      do_op(ra, rb, rad, model(ra, rb, rad), $sformatf("rnd%0d", i));
    end

    // Start pulsed while in PP1 with new operands: must be ignored.
    @(negedge clk);
    multiplicand = 32'd3; multiplier = 32'd5; addend = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; multiplicand = 32'd7; multiplier = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    dcnt = 0; snap = '0;
    for (int c = 0; c < 12; c++) begin
      if (done) begin dcnt++; snap = product; end
      @(posedge clk); #1;
    end
    chk("busy_start.done_count", 64'(dcnt), 64'd1);
    chk("busy_start.product", snap, 64'd15);

    // Start held high for 12 sampling edges: two operations, 6 cycles apart.
    @(negedge clk);
    multiplicand = 32'd11; multiplier = 32'd13; addend = '0; start = 1'b1;
    dcnt = 0; first = -1; second = -1; snap = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) begin
        dcnt++;
        snap = product;
        if (first < 0) first = c; else if (second < 0) second = c;
      end
    end
    start = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("held_start.done_count", 64'(dcnt), 64'd2);
    chk("held_start.spacing", 64'(second - first), 64'd6);
    chk("held_start.first_edge", 64'(first), 64'd4);
    chk("held_start.product", snap, 64'd143);

    // Asynchronous reset during PP2 discards the operation.
    @(negedge clk);
    multiplicand = 32'd5; multiplier = 32'd6; addend = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_reset.product", product, 64'h0);
    chk("mid_reset.busy", 64'(busy), 64'h0);
    chk("mid_reset.done", 64'(done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("mid_reset.no_activity", 64'(dcnt), 64'd0);
    do_op(32'd2, 32'h8000_0000, 32'h0, 64'h0000_0001_0000_0000, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
